// File: rtl/vga_timing_core.sv
// ---------------------------------------------------------------------------
// vga_timing_core
//
// Parametrised VGA timing generator and pixel pipeline. Walks a horizontal
// and vertical counter over the whole frame, asks the framebuffer for each
// visible pixel, and lines the returned colour up with HS/VS/DE so that
// everything leaving this block belongs to the same screen position.
//
// Ports
//   VGA_CLK      in   pixel clock, everything runs on its rising edge
//   RESET_N      in   synchronous reset, active low
//   PIX_REQ      out  fetch request, high for each visible pixel
//   PIX_X        out  requested column (0 when no request)
//   PIX_Y        out  requested row (0 when no request)
//   PIX_DATA     in   {R,G,B} returned FETCH_LATENCY cycles after PIX_REQ
//   TPG_SEL      in   picks the built-in colour bars instead of PIX_DATA
//   VGA_R/G/B    out  registered colour, forced to 0 outside the display area
//   VGA_HS       out  registered horizontal sync
//   VGA_VS       out  registered vertical sync
//   VGA_DE       out  registered display enable
//   FRAME_START  out  one-cycle pulse together with output pixel (0,0)
//
// Build option
//   VGA_TEST_PATTERN_EN  when defined, TPG_SEL=1 replaces PIX_DATA with eight
//                        vertical colour bars. When undefined TPG_SEL is
//                        accepted but ignored and no bar logic exists.
// ---------------------------------------------------------------------------
module vga_timing_core #(
   parameter int H_VISIBLE_AREA = 800,
   parameter int H_FRONT_PORCH  = 56,
   parameter int H_SYNC_PULSE   = 120,
   parameter int H_BACK_PORCH   = 64,
   parameter int V_VISIBLE_AREA = 600,
   parameter int V_FRONT_PORCH  = 37,
   parameter int V_SYNC_PULSE   = 6,
   parameter int V_BACK_PORCH   = 23,
   parameter int HSYNC_POLARITY = 0,
   parameter int VSYNC_POLARITY = 0,
   parameter int COLOR_BITS     = 4,
   parameter int FETCH_LATENCY  = 2,
   localparam int XW = (H_VISIBLE_AREA > 1) ? $clog2(H_VISIBLE_AREA) : 1,
   localparam int YW = (V_VISIBLE_AREA > 1) ? $clog2(V_VISIBLE_AREA) : 1,
   localparam int CW = 3 * COLOR_BITS
) (
   input  logic                  VGA_CLK,
   input  logic                  RESET_N,
   output logic                  PIX_REQ,
   output logic [XW-1:0]         PIX_X,
   output logic [YW-1:0]         PIX_Y,
   input  logic [CW-1:0]         PIX_DATA,
   input  logic                  TPG_SEL,
   output logic [COLOR_BITS-1:0] VGA_R,
   output logic [COLOR_BITS-1:0] VGA_G,
   output logic [COLOR_BITS-1:0] VGA_B,
   output logic                  VGA_HS,
   output logic                  VGA_VS,
   output logic                  VGA_DE,
   output logic                  FRAME_START
);

   localparam int WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int WHOLE_FRAME = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int HW = $clog2(WHOLE_LINE);
   localparam int VW = $clog2(WHOLE_FRAME);
   localparam int DL = FETCH_LATENCY - 1;

   localparam logic [HW-1:0] H_LAST     = HW'(WHOLE_LINE - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE_AREA);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [VW-1:0] V_LAST     = VW'(WHOLE_FRAME - 1);
   localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE_AREA);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

   localparam logic HS_IDLE = (HSYNC_POLARITY != 0);
   localparam logic VS_IDLE = (VSYNC_POLARITY != 0);

   logic [HW-1:0] hCnt_q, hCnt_d;
   logic [VW-1:0] vCnt_q, vCnt_d;

   logic          visible, hsPulse, vsPulse, firstPix;

   logic          pixReq_q;
   logic [XW-1:0] pixX_q;
   logic [YW-1:0] pixY_q;
   logic          hs0_q, vs0_q, de0_q, fs0_q;

   logic          hsDly_q [FETCH_LATENCY];
   logic          vsDly_q [FETCH_LATENCY];
   logic          deDly_q [FETCH_LATENCY];
   logic          fsDly_q [FETCH_LATENCY];

   logic [CW-1:0] pixSrc;
   logic [CW-1:0] rgb_q;
   logic          hs_q, vs_q, de_q, fs_q;

   // Next position on the raster: step along the line, and on the last
   // pixel of a line go back to column 0 and advance (or wrap) the row.
   always_comb begin
      hCnt_d = hCnt_q + HW'(1);
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + VW'(1);
      end
   end

   // Decode the current raster position into visible area, sync pulses and
   // the top-left pixel. The sync pulse windows start right after the front
   // porch of their own axis.
   always_comb begin
      visible  = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
      hsPulse  = (hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END);
      vsPulse  = (vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END);
      firstPix = (hCnt_q == '0) && (vCnt_q == '0);
   end

   // Raster counters plus the first pipeline stage: the fetch request goes
   // out together with the sync/DE flags of the same position, so the flags
   // can simply be delayed to meet the returning pixel data.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         hCnt_q   <= '0;
         vCnt_q   <= '0;
         pixReq_q <= 1'b0;
         pixX_q   <= '0;
         pixY_q   <= '0;
         hs0_q    <= HS_IDLE;
         vs0_q    <= VS_IDLE;
         de0_q    <= 1'b0;
         fs0_q    <= 1'b0;
      end else begin
         hCnt_q   <= hCnt_d;
         vCnt_q   <= vCnt_d;
         pixReq_q <= visible;
         pixX_q   <= visible ? XW'(hCnt_q) : '0;
         pixY_q   <= visible ? YW'(vCnt_q) : '0;
         hs0_q    <= hsPulse ^ HS_IDLE;
         vs0_q    <= vsPulse ^ VS_IDLE;
         de0_q    <= visible;
         fs0_q    <= firstPix;
      end
   end

   // Delay line that holds the control flags while the framebuffer is busy
   // producing the pixel. Reset fills it with idle values so nothing stale
   // reaches the pins after a mid-frame reset.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         for (int i = 0; i < FETCH_LATENCY; i++) begin
            hsDly_q[i] <= HS_IDLE;
            vsDly_q[i] <= VS_IDLE;
            deDly_q[i] <= 1'b0;
            fsDly_q[i] <= 1'b0;
         end
      end else begin
         hsDly_q[0] <= hs0_q;
         vsDly_q[0] <= vs0_q;
         deDly_q[0] <= de0_q;
         fsDly_q[0] <= fs0_q;
         for (int i = 1; i < FETCH_LATENCY; i++) begin
            hsDly_q[i] <= hsDly_q[i-1];
            vsDly_q[i] <= vsDly_q[i-1];
            deDly_q[i] <= deDly_q[i-1];
            fsDly_q[i] <= fsDly_q[i-1];
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [HW+2:0] barProd;
   logic [2:0]    bar0_d, bar0_q;
   logic [2:0]    barDly_q [FETCH_LATENCY];

   assign barProd = {hCnt_q, 3'b000};
   assign bar0_d  = 3'(barProd / (HW+3)'(H_VISIBLE_AREA));

   // The bar index travels down its own copy of the delay line so the
   // pattern has exactly the same latency as real framebuffer data.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         bar0_q <= '0;
         for (int i = 0; i < FETCH_LATENCY; i++) begin
            barDly_q[i] <= '0;
         end
      end else begin
         bar0_q      <= bar0_d;
         barDly_q[0] <= bar0_q;
         for (int i = 1; i < FETCH_LATENCY; i++) begin
            barDly_q[i] <= barDly_q[i-1];
         end
      end
   end

   // Each bar index bit lights one whole colour channel: bit 2 red,
   // bit 1 green, bit 0 blue.
   always_comb begin
      pixSrc = PIX_DATA;
      if (TPG_SEL) begin
         pixSrc = {{COLOR_BITS{barDly_q[DL][2]}},
                   {COLOR_BITS{barDly_q[DL][1]}},
                   {COLOR_BITS{barDly_q[DL][0]}}};
      end
   end
`else
   logic unusedTpgSel;

   assign unusedTpgSel = TPG_SEL;
   assign pixSrc       = PIX_DATA;
`endif

   // Output registers: pixel data is captured on the same edge the matching
   // flags leave the delay line. Colour is blanked whenever DE is low so the
   // DAC sees black during porches and sync even if the framebuffer returns
   // junk for unrequested cycles.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         rgb_q <= '0;
         hs_q  <= HS_IDLE;
         vs_q  <= VS_IDLE;
         de_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         rgb_q <= deDly_q[DL] ? pixSrc : '0;
         hs_q  <= hsDly_q[DL];
         vs_q  <= vsDly_q[DL];
         de_q  <= deDly_q[DL];
         fs_q  <= fsDly_q[DL];
      end
   end

   assign PIX_REQ     = pixReq_q;
   assign PIX_X       = pixX_q;
   assign PIX_Y       = pixY_q;
   assign VGA_R       = rgb_q[CW-1 -: COLOR_BITS];
   assign VGA_G       = rgb_q[COLOR_BITS +: COLOR_BITS];
   assign VGA_B       = rgb_q[0 +: COLOR_BITS];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_DE      = de_q;
   assign FRAME_START = fs_q;

endmodule
